// File: rtl/spi_cmd_seq.sv
// Command sequencer for an SPI driver: queues {tx word, clock count} commands,
// issues them one at a time and holds each received word until it is consumed.
//
// state | meaning
// IDLE  | waiting for a queued command; pops the head and validates its count
// ISSUE | start_cmd held high until the driver reports busy (rdy low)
// XFER  | driver busy; rx_miso captured when rdy returns high
// RESP  | response held until rsp_ready
module spi_cmd_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CLKS   = 32
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [31:0]                 cmd_tx_data,
  input  logic [31:0]                 cmd_n_clks,
  output logic                        start_cmd,
  input  logic                        spi_drv_rdy,
  output logic [31:0]                 tx_data,
  output logic [31:0]                 n_clks,
  input  logic [31:0]                 rx_miso,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_data,
  output logic                        err_drop,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  localparam logic [31:0] MAX_N = MAX_CLKS[31:0];

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RESP} state_t;

  state_t        state;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   head_tx;
  logic [31:0]   head_n;
  logic          head_ok;
  logic          push;
  logic          pop;

  assign cmd_ready  = (count != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head_tx    = mem[rd_ptr][63:32];
  assign head_n     = mem[rd_ptr][31:0];
  assign head_ok    = (head_n != 32'd0) && (head_n <= MAX_N);
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_tx_data, cmd_n_clks};
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      start_cmd <= 1'b0;
      tx_data   <= '0;
      n_clks    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err_drop  <= 1'b0;
    end else begin
      err_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_ok) begin
              tx_data   <= head_tx;
              n_clks    <= head_n;
              start_cmd <= 1'b1;
              state     <= ISSUE;
            end else begin
              err_drop <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!spi_drv_rdy) begin
            start_cmd <= 1'b0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (spi_drv_rdy) begin
            rsp_data  <= rx_miso;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          start_cmd <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_seq.md
SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, which sets the command FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter MAX_CLKS, default 32, which sets the largest legal n_clks value.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active; one clock, and all logic is in this domain.
REQ-004 SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: the command offer.
REQ-006 SHALL have port cmd_ready, output, 1 bit: FIFO not full.
REQ-007 SHALL have port cmd_tx_data, input, 32 bits: the MOSI word of the command.
REQ-008 SHALL have port cmd_n_clks, input, 32 bits: the SCLK count of the command.
REQ-009 SHALL have port start_cmd, output, 1 bit: the start request to spi_drv.
REQ-010 SHALL have port spi_drv_rdy, input, 1 bit: spi_drv is idle.
REQ-011 SHALL have port tx_data, output, 32 bits: the word presented to spi_drv.
REQ-012 SHALL have port n_clks, output, 32 bits: the count presented to spi_drv.
REQ-013 SHALL have port rx_miso, input, 32 bits: the received word from spi_drv.
REQ-014 SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-015 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-016 SHALL have port rsp_data, output, 32 bits: the captured rx_miso.
REQ-017 SHALL have port err_drop, output, 1 bit: a one-cycle pulse when an illegal command is discarded.
REQ-018 SHALL have port busy, output, 1 bit: the FSM is not IDLE or the FIFO is not empty.
REQ-019 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: the number of entries held.

Function
REQ-020 SHALL push {cmd_tx_data, cmd_n_clks} into the FIFO when cmd_valid and cmd_ready are both 1 on a rising edge; cmd_ready = (fifo_count != FIFO_DEPTH).
REQ-021 SHALL allow a push and a pop in the same cycle, leaving fifo_count unchanged; a push while full is impossible because cmd_ready is 0.
REQ-022 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, and the FIFO SHALL be first in, first out.
REQ-023 SHALL implement the FSM states IDLE, ISSUE, XFER and RESP.
REQ-024 SHALL, in IDLE with the FIFO not empty, pop the head entry: if the head n_clks is 0 or greater than MAX_CLKS, the FSM SHALL discard it, pulse err_drop for 1 cycle and stay in IDLE; otherwise it SHALL register tx_data and n_clks and go to ISSUE.
REQ-025 SHALL, in ISSUE, drive start_cmd = 1 and hold it until a cycle samples spi_drv_rdy = 0, then go to XFER.
REQ-026 SHALL drive start_cmd = 0 in every state other than ISSUE.
REQ-027 SHALL, in XFER, wait for spi_drv_rdy = 1; on that edge the block SHALL capture rx_miso into rsp_data, set rsp_valid and go to RESP.
REQ-028 SHALL, in RESP, hold rsp_valid and rsp_data stable until rsp_ready = 1; on that edge it SHALL clear rsp_valid and return to IDLE.
REQ-029 SHALL keep tx_data and n_clks stable from entry to ISSUE until the next load, so they never change while spi_drv is active.
REQ-030 SHALL have a latency of: push at edge N with the FSM in IDLE and the FIFO empty, then load at N+1, then start_cmd high in the cycle after N+1.
REQ-031 SHALL, when rsp_ready is already 1 on entry to RESP, return the FSM to IDLE one cycle after the capture, so a back-to-back command loads on the following edge.
REQ-032 SHALL keep accepting commands into the FIFO in every FSM state.

Reset
REQ-033 SHALL, while areset = 1, immediately force: FSM = IDLE, FIFO empty, fifo_count = 0, cmd_ready = 1, start_cmd = 0, tx_data = 0, n_clks = 0, rsp_valid = 0, rsp_data = 0, err_drop = 0, busy = 0.
REQ-034 SHALL, when reset asserts mid-transfer, lose all queued commands and any pending response, and SHALL NOT emit any further start_cmd until a new push.
REQ-035 SHALL operate normally from the first rising clk edge after areset deasserts.

Verification
REQ-036 SHALL be verified with a single command: push tx 0x0000000C, n_clks 4; a spi_drv model drops rdy 2 cycles after start_cmd and raises it 200 cycles later with rx_miso 0x0000000A -> start_cmd high for exactly 3 cycles, tx_data = 0xC and n_clks = 4 throughout, rsp_data = 0xA, rsp_valid set 1 cycle after rdy rises.
REQ-037 SHALL be verified with back-pressure: push 5 commands at FIFO_DEPTH 4 while rdy is held 0 -> cmd_ready = 0 after 4 pushes (or after 5 if one pop already occurred), with no loss and no duplication, and responses arrive in push order.
REQ-038 SHALL be verified with an illegal count: push n_clks 0, then 33, then 8 -> err_drop pulses twice, start_cmd is issued only for the n_clks 8 command.
REQ-039 SHALL be verified with response stall: rsp_ready is held 0 for 50 cycles after the capture -> rsp_data is stable, no new start_cmd is issued, queued commands remain, and the next command loads 1 cycle after acceptance.
REQ-040 SHALL be verified with reset mid-XFER: areset pulses with 2 commands queued -> all outputs reach their reset values without a clk edge, and no start_cmd appears after reset until a new push.
REQ-041 SHALL be verified with simultaneous push and pop: the FIFO holds 2 entries, the FSM pops in IDLE while cmd_valid = 1 -> fifo_count stays at 2.
